rtc_timekeeper: RTL and testbench
=================================

Name: rtc_timekeeper

Overview:
- Parametrised time-of-day counter (hh:mm:ss) for the user-project area; successor to the fixed 50 MHz clock block.
- Adds a configurable input frequency, an exact one-second prescaler, a run/hold control, a validated time-set load port, 12/24-hour display mode and a one-cycle seconds strobe.
- Outputs drive GPIO pads directly; the management SoC sets and reads time via LA/wishbone glue outside this block.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz; prescaler terminal count = CLK_HZ-1; must be >= 2.
- PRE_W, $clog2(CLK_HZ), prescaler counter width (derived; not for override).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- run  input  1  1 = timekeeping advances; 0 = prescaler and time held
- set_valid  input  1  one-cycle request to load set_hours/set_minutes/set_seconds
- set_hours  input  5  load value, 0-23 (always 24-hour)
- set_minutes  input  6  load value, 0-59
- set_seconds  input  6  load value, 0-59
- mode_12h  input  1  0 = 24-hour display, 1 = 12-hour display
- set_err  output  1  one-cycle pulse: set request rejected (field out of range)
- sec_pulse  output  1  one-cycle pulse on every seconds increment
- hours  output  5  displayed hours: 0-23, or 1-12 when mode_12h
- pm  output  1  1 when internal hour >= 12 (valid in both modes)
- minutes  output  6  0-59
- seconds  output  6  0-59

Behaviour:
- Reset (async assert): internal time 00:00:00; prescaler 0; set_err=0; sec_pulse=0; pm=0; hours=0, or 12 if mode_12h is sampled high after reset release (hours is a combinational decode of the internal hour register and mode_12h).
- Prescaler:
  - Counts 0..CLK_HZ-1 while run=1.
  - Tick asserted in the cycle count==CLK_HZ-1; count wraps to 0.
  - Exactly CLK_HZ cycles per second (fixes the old >= 50000000 off-by-one).
  - run=0 freezes count; no tick.
- On tick:
  - seconds+1; 59 wraps to 0 with carry to minutes.
  - minutes 59 wraps to 0 with carry to hours.
  - hours 23 wraps to 0.
  - All carries resolve in the same cycle; 23:59:59 -> 00:00:00 on a single tick.
  - sec_pulse=1 in the cycle after the tick (registered with the time update).
- Set port:
  - set_valid sampled each cycle; accepted iff set_hours<=23, set_minutes<=59 and set_seconds<=59.
  - Accepted: time registers take the set values next cycle; prescaler cleared to 0; no sec_pulse.
  - Rejected: time and prescaler unchanged; set_err=1 for one cycle.
  - Set is honoured regardless of run.
- Simultaneous set_valid and tick: an accepted set wins and the tick is discarded. A rejected set does not suppress the tick; both set_err and sec_pulse fire.
- 12-hour decode: internal 0 -> 12 (pm=0); 1-11 -> 1-11 (pm=0); 12 -> 12 (pm=1); 13-23 -> 1-11 (pm=1). mode_12h may change any cycle; takes effect combinationally, with no state change.
- Reset mid-count or mid-set: all state cleared immediately; an in-flight set is lost.
- All arithmetic unsigned; field registers never hold out-of-range values.

Optional Feature:
- Macro RTC_ALARM_EN.
- Defined: adds inputs alarm_wr (1), alarm_hours (5), alarm_minutes (6), alarm_arm (1) and output alarm_irq (1).
  - alarm_wr loads the alarm registers; values out of range are rejected silently. Reset values: 00:00, disarmed.
  - alarm_irq pulses one cycle when a tick or accepted set makes the time equal alarm hh:mm:00 while alarm_arm=1.
- Undefined: no alarm ports or logic; the port list is exactly as above.

Decomposition:
- Package rtc_pkg:
  - MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59
  - HOUR_W=5, MIN_W=6, SEC_W=6
  - typedef rtc_time_t (packed hours/minutes/seconds)
  - function to_12h (hour -> display hour, pm)
- Sub-module rtc_prescaler (CLK_HZ, clk, reset, run, clear -> tick).
- Field counters and set validation stay in the top level.

Test Plan (CLK_HZ=4):
- Reset, run=1, 16 clk -> seconds 0->4, sec_pulse exactly every 4th cycle, minutes/hours 0.
- set_valid 23:59:58, run=1, 8 clk -> 23:59:59 then 00:00:00, pm 1->0; mode_12h=1 shows hours 11 then 12.
- set_valid with set_minutes=60 -> set_err one cycle, time unchanged; set 25:00:00 -> set_err, unchanged.
- set_valid 10:20:30 asserted in the prescaler tick cycle -> time=10:20:30, no sec_pulse, next increment exactly 4 cycles later.
- run=0 for 10 cycles at 00:00:02 -> no change, no sec_pulse; run=1 resumes from the held prescaler count.
- Assert reset mid-count at 12:34:56 -> immediate 00:00:00; with RTC_ALARM_EN, alarm 00:01 armed -> alarm_irq one cycle at 00:01:00 only.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared types, field limits and the 12-hour decode helper for the
// rtc_timekeeper time-of-day block.
package rtc_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
    localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
        logic [SEC_W-1:0]  seconds;
    } rtc_time_t;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic              pm;
    } rtc_hour12_t;

    // Map a 0-23 hour onto the 1-12 clock face plus the afternoon flag.
    function automatic rtc_hour12_t to_12h(input logic [HOUR_W-1:0] hour);
        rtc_hour12_t r;
        r.pm = (hour >= 5'd12);
        if (hour == 5'd0 || hour == 5'd12) begin
            r.hour = 5'd12;
        end else if (hour > 5'd12) begin
            r.hour = hour - 5'd12;
        end else begin
            r.hour = hour;
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the input clock down to one tick per second. The terminal count
// is CLK_HZ-1 so a second spans exactly CLK_HZ cycles.
module rtc_prescaler #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int PRE_W = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0] TERMINAL = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] count;

    assign tick = run && (count == TERMINAL);

    // Free-running divider: cleared by a time load, frozen while not running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// hh:mm:ss time-of-day counter with validated time load, run/hold control,
// 12/24-hour display decode and a one-cycle seconds strobe.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              set_valid,
    input  logic [HOUR_W-1:0] set_hours,
    input  logic [MIN_W-1:0]  set_minutes,
    input  logic [SEC_W-1:0]  set_seconds,
    input  logic              mode_12h,
    output logic              set_err,
    output logic              sec_pulse,
    output logic [HOUR_W-1:0] hours,
    output logic              pm,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds
`ifdef RTC_ALARM_EN
    ,
    input  logic              alarm_wr,
    input  logic [HOUR_W-1:0] alarm_hours,
    input  logic [MIN_W-1:0]  alarm_minutes,
    input  logic              alarm_arm,
    output logic              alarm_irq
`endif
);

    rtc_time_t   time_q;
    rtc_time_t   inc_time;
    rtc_time_t   next_time;
    rtc_hour12_t disp;
    logic        tick;
    logic        set_ok;

    assign set_ok = set_valid && (set_hours <= MAX_HOUR) &&
                    (set_minutes <= MAX_MIN) && (set_seconds <= MAX_SEC);

    rtc_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .run  (run),
        .clear(set_ok),
        .tick (tick)
    );

    // One-second increment with all carries resolved in a single step.
    always_comb begin
        inc_time = time_q;
        if (time_q.seconds == MAX_SEC) begin
            inc_time.seconds = '0;
            if (time_q.minutes == MAX_MIN) begin
                inc_time.minutes = '0;
                if (time_q.hours == MAX_HOUR) begin
                    inc_time.hours = '0;
                end else begin
                    inc_time.hours = time_q.hours + HOUR_W'(1);
                end
            end else begin
                inc_time.minutes = time_q.minutes + MIN_W'(1);
            end
        end else begin
            inc_time.seconds = time_q.seconds + SEC_W'(1);
        end
    end

    // An accepted load takes priority over a coincident tick.
    always_comb begin
        next_time = inc_time;
        if (set_ok) begin
            next_time.hours   = set_hours;
            next_time.minutes = set_minutes;
            next_time.seconds = set_seconds;
        end
    end

    // Time registers plus the registered strobe and rejection pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_q    <= '0;
            sec_pulse <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            set_err   <= set_valid && !set_ok;
            sec_pulse <= tick && !set_ok;
            if (set_ok || tick) begin
                time_q <= next_time;
            end
        end
    end

    assign disp    = to_12h(time_q.hours);
    assign hours   = mode_12h ? disp.hour : time_q.hours;
    assign pm      = disp.pm;
    assign minutes = time_q.minutes;
    assign seconds = time_q.seconds;

`ifdef RTC_ALARM_EN
    logic [HOUR_W-1:0] alarm_h;
    logic [MIN_W-1:0]  alarm_m;

    // Alarm registers load only in-range values; the pulse fires when an
    // update lands exactly on hh:mm:00 while armed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_h   <= '0;
            alarm_m   <= '0;
            alarm_irq <= 1'b0;
        end else begin
            if (alarm_wr && (alarm_hours <= MAX_HOUR) && (alarm_minutes <= MAX_MIN)) begin
                alarm_h <= alarm_hours;
                alarm_m <= alarm_minutes;
            end
            alarm_irq <= alarm_arm && (set_ok || tick) &&
                         (next_time.hours == alarm_h) &&
                         (next_time.minutes == alarm_m) &&
                         (next_time.seconds == '0);
        end
    end
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Randomized self-checking bench for rtc_timekeeper (CLK_HZ=4). The reference
// keeps time as seconds-of-day and a prescaler phase in plain integers.
module tb_rtc_timekeeper;

    localparam int CLK_HZ = 4;
    localparam int DAY    = 86400;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       set_valid;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;
    logic       mode_12h;
    logic       set_err;
    logic       sec_pulse;
    logic [4:0] hours;
    logic       pm;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       alarm_wr;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       alarm_arm;
`ifdef RTC_ALARM_EN
    logic       alarm_irq;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state
    int m_tod, m_phase, m_ah, m_am;
    bit m_pulse, m_err, m_irq;

    always #5 clk = ~clk;

    rtc_timekeeper #(.CLK_HZ(CLK_HZ)) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .set_valid    (set_valid),
        .set_hours    (set_hours),
        .set_minutes  (set_minutes),
        .set_seconds  (set_seconds),
        .mode_12h     (mode_12h),
        .set_err      (set_err),
        .sec_pulse    (sec_pulse),
        .hours        (hours),
        .pm           (pm),
        .minutes      (minutes),
        .seconds      (seconds)
`ifdef RTC_ALARM_EN
        ,
        .alarm_wr     (alarm_wr),
        .alarm_hours  (alarm_hours),
        .alarm_minutes(alarm_minutes),
        .alarm_arm    (alarm_arm),
        .alarm_irq    (alarm_irq)
`endif
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic int dispHour(input int tod, input bit m12);
        int h;
        h = tod / 3600;
        if (!m12) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    // Reference: seconds-of-day arithmetic driven by the sampled inputs.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tod = 0; m_phase = 0; m_pulse = 0; m_err = 0; m_irq = 0;
            m_ah = 0; m_am = 0;
        end else begin
            bit tk, ok;
            int nt;
            tk = run && (m_phase == CLK_HZ - 1);
            ok = set_valid && int'(set_hours) < 24 && int'(set_minutes) < 60 &&
                 int'(set_seconds) < 60;
            m_err   = set_valid && !ok;
            m_pulse = tk && !ok;
            if (ok)      nt = int'(set_hours) * 3600 + int'(set_minutes) * 60 + int'(set_seconds);
            else if (tk) nt = (m_tod + 1) % DAY;
            else         nt = m_tod;
            m_irq = alarm_arm && (ok || tk) && (nt == m_ah * 3600 + m_am * 60);
            if (alarm_wr && int'(alarm_hours) < 24 && int'(alarm_minutes) < 60) begin
                m_ah = int'(alarm_hours);
                m_am = int'(alarm_minutes);
            end
            m_tod = nt;
            if (ok)       m_phase = 0;
            else if (run) m_phase = (m_phase + 1) % CLK_HZ;
        end
    end

    // Compare every output against the reference on each falling edge.
    always @(negedge clk) begin
        checkOutput("hours",     int'(hours),     dispHour(m_tod, mode_12h));
        checkOutput("pm",        int'(pm),        int'(m_tod >= 12 * 3600));
        checkOutput("minutes",   int'(minutes),   (m_tod / 60) % 60);
        checkOutput("seconds",   int'(seconds),   m_tod % 60);
        checkOutput("sec_pulse", int'(sec_pulse), int'(m_pulse));
        checkOutput("set_err",   int'(set_err),   int'(m_err));
`ifdef RTC_ALARM_EN
        checkOutput("alarm_irq", int'(alarm_irq), int'(m_irq));
`endif
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applySet(input int h, input int m, input int s);
        set_valid   = 1'b1;
        set_hours   = 5'(h);
        set_minutes = 6'(m);
        set_seconds = 6'(s);
        waitCycles(1);
        set_valid   = 1'b0;
    endtask

    // Literal expectation on both the DUT and the reference time.
    task automatic expectTime(input string tag, input int h, input int m, input int s);
        checkOutput({tag, "_dut_h"}, int'(dut.time_q.hours), h);
        checkOutput({tag, "_dut_m"}, int'(minutes), m);
        checkOutput({tag, "_dut_s"}, int'(seconds), s);
        checkOutput({tag, "_model"}, m_tod, h * 3600 + m * 60 + s);
    endtask

    // One cycle of randomized inputs, biased toward rollover boundaries.
    task automatic applyStimulus();
        reset     = ($urandom_range(0, 299) == 0);
        run       = ($urandom_range(0, 9) != 0);
        mode_12h  = ($urandom_range(0, 7) == 0) ? ~mode_12h : mode_12h;
        set_valid = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 2) == 0) begin
            set_hours   = 5'($urandom_range(0, 31));
            set_minutes = 6'($urandom_range(0, 63));
            set_seconds = 6'($urandom_range(0, 63));
        end else begin
            set_hours   = ($urandom_range(0, 1) == 0) ? 5'd23 : 5'($urandom_range(0, 23));
            set_minutes = 6'($urandom_range(57, 59));
            set_seconds = 6'($urandom_range(50, 59));
        end
        alarm_wr      = ($urandom_range(0, 29) == 0);
        alarm_hours   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : hours;
        alarm_minutes = 6'($urandom_range(0, 63));
        alarm_arm     = ($urandom_range(0, 1) == 0);
        waitCycles(1);
    endtask

    initial begin
        int irqs;
        reset = 1'b1; run = 1'b0; set_valid = 1'b0; mode_12h = 1'b0;
        set_hours = '0; set_minutes = '0; set_seconds = '0;
        alarm_wr = 1'b0; alarm_hours = '0; alarm_minutes = '0; alarm_arm = 1'b0;
        waitCycles(2);
        expectTime("reset", 0, 0, 0);
        checkOutput("reset_pm", int'(pm), 0);
        reset = 1'b0;

        // 16 running cycles -> four seconds
        run = 1'b1;
        waitCycles(16);
        expectTime("run16", 0, 0, 4);

        // Midnight rollover with 12-hour display
        applySet(23, 59, 58);
        expectTime("set_late", 23, 59, 58);
        waitCycles(4);
        expectTime("late_p1", 23, 59, 59);
        mode_12h = 1'b1; #1;
        checkOutput("h12_eleven", int'(hours), 11);
        checkOutput("pm_before", int'(pm), 1);
        waitCycles(4);
        expectTime("midnight", 0, 0, 0);
        checkOutput("h12_twelve", int'(hours), 12);
        checkOutput("pm_after", int'(pm), 0);
        mode_12h = 1'b0;

        // Rejected loads
        run = 1'b0;
        applySet(0, 0, 0);
        applySet(1, 60, 0);
        checkOutput("err_min60", int'(set_err), 1);
        expectTime("rej1", 0, 0, 0);
        applySet(25, 0, 0);
        checkOutput("err_h25", int'(set_err), 1);
        expectTime("rej2", 0, 0, 0);

        // Load coinciding with the tick cycle
        run = 1'b1;
        applySet(0, 0, 0);
        waitCycles(3);
        applySet(10, 20, 30);
        expectTime("set_tick", 10, 20, 30);
        checkOutput("set_tick_pulse", int'(sec_pulse), 0);
        waitCycles(3);
        expectTime("set_tick_hold", 10, 20, 30);
        waitCycles(1);
        expectTime("set_tick_next", 10, 20, 31);
        checkOutput("set_tick_p2", int'(sec_pulse), 1);

        // Hold with run low, resume from held phase
        applySet(0, 0, 1);
        waitCycles(4);
        waitCycles(2);
        run = 1'b0;
        waitCycles(10);
        expectTime("hold", 0, 0, 2);
        run = 1'b1;
        waitCycles(1);
        expectTime("resume1", 0, 0, 2);
        waitCycles(1);
        expectTime("resume2", 0, 0, 3);

        // Async reset mid-count
        applySet(12, 34, 56);
        waitCycles(2);
        reset = 1'b1; #1;
        expectTime("async_rst", 0, 0, 0);
        waitCycles(1);
        reset = 1'b0;

`ifdef RTC_ALARM_EN
        alarm_wr = 1'b1; alarm_hours = 5'd0; alarm_minutes = 6'd1; alarm_arm = 1'b1;
        waitCycles(1);
        alarm_wr = 1'b0;
        applySet(0, 0, 58);
        irqs = 0;
        for (int i = 0; i < 16; i++) begin
            waitCycles(1);
            if (alarm_irq) irqs++;
        end
        checkOutput("alarm_irq_count", irqs, 1);
        alarm_arm = 1'b0;
`else
        irqs = 0;
`endif

        // Randomized soak
        for (int i = 0; i < 3000; i++) applyStimulus();
        reset = 1'b0;
        waitCycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
